// File: rtl/dpram_rmw_ctrl_if.sv
// Request/response channel bundle for dpram_rmw_ctrl.
// The master drives requests and accepts responses; the slave is the controller.
interface dpram_rmw_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ovf;

  modport master (
    output req_valid, req_op, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ovf
  );
endinterface

// File: rtl/dpram_rmw_ctrl.sv
// Read-modify-write controller for a synchronous dual-port RAM (port 0 reads, port 1 writes).
// Define RMW_SAT_EN to make ADD saturate to all-ones instead of wrapping.
module dpram_rmw_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dpram_rmw_ctrl_if.slave  bus,
  output logic             init_done,
  output logic             ram_p0_en,
  output logic [AW-1:0]    ram_p0_addr,
  output logic             ram_p0_we,
  output logic [WIDTH-1:0] ram_p0_din,
  input  logic [WIDTH-1:0] ram_p0_dout,
  output logic             ram_p1_en,
  output logic [AW-1:0]    ram_p1_addr,
  output logic             ram_p1_we,
  output logic [WIDTH-1:0] ram_p1_din
);

  localparam logic [2:0] StInit = 3'd0;
  localparam logic [2:0] StIdle = 3'd1;
  localparam logic [2:0] StRd   = 3'd2;
  localparam logic [2:0] StWr   = 3'd3;
  localparam logic [2:0] StRsp  = 3'd4;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpAdd   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
  localparam bit            Pow2     = (DEPTH == (32'd1 << AW));

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    init_addr_q, init_addr_d;
  logic [1:0]       op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             init_done_q, init_done_d;

  logic             addr_ok;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] add_val;
  logic [WIDTH-1:0] new_val;

  always_comb begin
    addr_ok = Pow2 ? 1'b1 : ({1'b0, addr_q} < DepthW);
    old_val = addr_ok ? ram_p0_dout : '0;
    sum     = {1'b0, old_val} + {1'b0, data_q};
`ifdef RMW_SAT_EN
    add_val = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    add_val = sum[WIDTH-1:0];
`endif
    unique case (op_q)
      OpWrite: new_val = data_q;
      OpAdd:   new_val = add_val;
      OpClear: new_val = '0;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    rsp_data_d    = rsp_data_q;
    rsp_ovf_d     = rsp_ovf_q;
    init_done_d   = init_done_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    ram_p0_en     = 1'b0;
    ram_p0_addr   = '0;
    ram_p0_we     = 1'b0;
    ram_p0_din    = '0;
    ram_p1_en     = 1'b0;
    ram_p1_addr   = '0;
    ram_p1_we     = 1'b0;
    ram_p1_din    = '0;

    case (state_q)
      StInit: begin
        ram_p1_en   = 1'b1;
        ram_p1_we   = 1'b1;
        ram_p1_addr = init_addr_q;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LastAddr) begin
          init_addr_d = '0;
          init_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          data_d  = bus.req_data;
          state_d = StRd;
        end
      end
      StRd: begin
        ram_p0_en   = 1'b1;
        ram_p0_addr = addr_q;
        state_d     = StWr;
      end
      StWr: begin
        rsp_data_d = old_val;
        rsp_ovf_d  = (op_q == OpAdd) && sum[WIDTH] && addr_ok;
        if ((op_q != OpRead) && addr_ok) begin
          ram_p1_en   = 1'b1;
          ram_p1_we   = 1'b1;
          ram_p1_addr = addr_q;
          ram_p1_din  = new_val;
        end
        state_d = StRsp;
      end
      StRsp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase

    // The reset state is INIT, whose sweep write must stay invisible until reset is released.
    if (!rst_n) begin
      ram_p1_en   = 1'b0;
      ram_p1_we   = 1'b0;
      ram_p1_addr = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_addr_q <= '0;
      op_q        <= OpRead;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_ovf  = rsp_ovf_q;
  assign init_done    = init_done_q;

endmodule
